dtree_walk_engine: RTL and testbench

- Sequential, programmable successor to the team's fixed combinational classifier trees: one tree is held in a node table.
- The tree is walked one node per clock over a latched feature vector, producing a class label.
- Feature count, feature width, table depth, class width and maximum walk depth are parameters.
- Sits between the feature-extraction stage (valid/ready in) and the vote/aggregation stage (valid/ready out).
- The node table is written through a config port while the engine is idle.

---
 rtl/dtree_walk_engine.sv | 137 +++++++++++++
 tb/tb_dtree_walk_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_walk_engine.sv
// rtl/dtree_walk_engine.sv - programmable decision-tree walker, one node per clock
module dtree_walk_engine #(
  parameter int N_FEAT    = 51,
  parameter int FEAT_W    = 1,
  parameter int NODE_AW   = 6,
  parameter int CLASS_W   = 2,
  parameter int MAX_DEPTH = 16,
  parameter int FIDX_W    = $clog2(N_FEAT),
  localparam int NW       = 1 + FIDX_W + FEAT_W + 2*NODE_AW + CLASS_W,
  localparam int DEPTH_W  = $clog2(MAX_DEPTH+1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [NODE_AW-1:0]       cfg_addr,
  input  logic [NW-1:0]            cfg_wdata,
  output logic                     cfg_ready,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic [DEPTH_W-1:0]       out_depth,
  output logic                     out_err
);

  localparam int N_NODES = 1 << NODE_AW;
  localparam logic [NW-1:0] NODE_RESET = {1'b1, {(NW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t                  state, state_nxt;
  logic [NW-1:0]           node_tab [N_NODES];
  logic [N_FEAT*FEAT_W-1:0] feat_q;
  logic [NODE_AW-1:0]      node_q;
  logic [DEPTH_W-1:0]      depth_q;
  logic [CLASS_W-1:0]      cls_q;
  logic                    err_q;

  // Field decode of the node currently being visited
  logic [NW-1:0]      cur;
  logic               cur_leaf;
  logic [FIDX_W-1:0]  cur_fidx;
  logic [FEAT_W-1:0]  cur_thr;
  logic [NODE_AW-1:0] cur_left, cur_right;
  logic [CLASS_W-1:0] cur_cls;
  logic [FEAT_W-1:0]  feat_sel;
  logic               bad_fidx, depth_hit, walk_end;
  logic [NODE_AW-1:0] child;

  assign cur       = node_tab[node_q];
  assign cur_leaf  = cur[NW-1];
  assign cur_fidx  = cur[NW-2 -: FIDX_W];
  assign cur_thr   = cur[NW-2-FIDX_W -: FEAT_W];
  assign cur_left  = cur[2*NODE_AW+CLASS_W-1 -: NODE_AW];
  assign cur_right = cur[NODE_AW+CLASS_W-1 -: NODE_AW];
  assign cur_cls   = cur[CLASS_W-1:0];

  // Out-of-range indices select nothing; bad_fidx aborts the walk instead
  always_comb begin
    feat_sel = '0;
    for (int k = 0; k < N_FEAT; k++)
      if (cur_fidx == FIDX_W'(k)) feat_sel = feat_q[k*FEAT_W +: FEAT_W];
  end

  assign bad_fidx  = {1'b0, cur_fidx} >= (FIDX_W+1)'(N_FEAT);
  assign depth_hit = depth_q == DEPTH_W'(MAX_DEPTH);
  assign walk_end  = cur_leaf || bad_fidx || depth_hit;
  assign child     = (feat_sel > cur_thr) ? cur_right : cur_left;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        in_ready  = !cfg_we;
        if (in_valid && !cfg_we) state_nxt = WALK;
      end
      WALK: if (walk_end) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NODES; k++) node_tab[k] <= NODE_RESET;
    end else if (state == IDLE && cfg_we) begin
      node_tab[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_q  <= '0;
      node_q  <= '0;
      depth_q <= '0;
      cls_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          feat_q  <= i;
          node_q  <= '0;
          depth_q <= '0;
        end
        WALK: begin
          if (cur_leaf) begin
            cls_q <= cur_cls;
            err_q <= 1'b0;
          end else if (bad_fidx || depth_hit) begin
            cls_q <= '0;
            err_q <= 1'b1;
          end else begin
            node_q  <= child;
            depth_q <= depth_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign out_class = cls_q;
  assign out_depth = depth_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_dtree_walk_engine.sv
// tb/tb_dtree_walk_engine.sv - self-checking bench for dtree_walk_engine
module tb_dtree_walk_engine;

  localparam int NF = 51;
  localparam int NW = 22;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [5:0]    cfg_addr;
  logic [NW-1:0] cfg_wdata;
  logic          cfg_ready;
  logic          in_valid;
  logic          in_ready;
  logic [NF-1:0] i;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_class;
  logic [4:0]    out_depth;
  logic          out_err;

  dtree_walk_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .i(i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_depth(out_depth), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {int leaf; int fidx; int thr; int left; int right; int cls;} node_t;
  typedef struct {string name; logic [NF-1:0] feat; int cls; int dep; int err;} vec_t;

  node_t m_tab [64];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic node_t mk(int leaf, int fidx, int thr, int left, int right, int cls);
    node_t n;
    n.leaf = leaf; n.fidx = fidx; n.thr = thr; n.left = left; n.right = right; n.cls = cls;
    return n;
  endfunction

  function automatic logic [NW-1:0] pack(node_t n);
    return {1'(n.leaf), 6'(n.fidx), 1'(n.thr), 6'(n.left), 6'(n.right), 2'(n.cls)};
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 64; a++) m_tab[a] = mk(1, 0, 0, 0, 0, 0);
  endtask

  // Reference walk: follow the tree from node 0 until a leaf or an abort condition
  function automatic void model_walk(input logic [NF-1:0] f, output int cls, output int dep,
                                     output int err);
    int n;
    cls = 0; dep = 0; err = 0; n = 0;
    for (int step = 0; step < 100; step++) begin
      if (m_tab[n].leaf != 0) begin
        cls = m_tab[n].cls;
        return;
      end
      if (m_tab[n].fidx >= NF || dep == 16) begin
        err = 1;
        return;
      end
      n = (int'(f[m_tab[n].fidx]) > m_tab[n].thr) ? m_tab[n].right : m_tab[n].left;
      dep++;
    end
  endfunction

  task automatic cfg_write(input int addr, input node_t n);
    cfg_we = 1'b1;
    cfg_addr = 6'(addr);
    cfg_wdata = pack(n);
    @(posedge clk);
    #1 cfg_we = 1'b0;
    m_tab[addr] = n;
  endtask

  task automatic send(input logic [NF-1:0] feat);
    i = feat;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    i = NF'({$urandom, $urandom});
  endtask

  task automatic wait_result(input string name, input int ecls, input int edep, input int eerr,
                             input int elat, input bit do_hs);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = out_valid;
    end
    if (!got) begin
      check({name, " timeout"}, 32'(out_valid), 32'(1));
    end else begin
      check({name, " latency"}, 32'(lat), 32'(elat));
      check({name, " class"}, 32'(out_class), 32'(ecls));
      check({name, " depth"}, 32'(out_depth), 32'(edep));
      check({name, " err"}, 32'(out_err), 32'(eerr));
    end
    if (do_hs) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic run_vec(input string name, input logic [NF-1:0] feat);
    int c, d, e;
    model_walk(feat, c, d, e);
    send(feat);
    wait_result(name, c, d, e, d + 1, 1'b1);
  endtask

  task automatic program_test_tree();
    cfg_write(0, mk(0, 50, 0, 2, 1, 0));
    cfg_write(1, mk(1, 0, 0, 0, 0, 0));
    cfg_write(2, mk(0, 18, 0, 3, 4, 0));
    cfg_write(3, mk(1, 0, 0, 0, 0, 2));
    cfg_write(4, mk(1, 0, 0, 0, 0, 1));
  endtask

  vec_t tv [3];
  logic [NF-1:0] f50, f18;

  initial begin
    f50 = '0; f50[50] = 1'b1;
    f18 = '0; f18[18] = 1'b1;
    tv[0] = '{"f50_set",    f50 | f18, 0, 1, 0};
    tv[1] = '{"f18_set",    f18,       1, 2, 0};
    tv[2] = '{"both_clear", '0,        2, 2, 0};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; i = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'(1));
    check("rst cfg_ready", 32'(cfg_ready), 32'(1));
    check("rst out_valid", 32'(out_valid), 32'(0));
    check("rst out_class", 32'(out_class), 32'(0));
    check("rst out_depth", 32'(out_depth), 32'(0));
    check("rst out_err", 32'(out_err), 32'(0));

    send('0);
    wait_result("default", 0, 0, 0, 1, 1'b1);

    program_test_tree();
    for (int k = 0; k < 3; k++) begin
      send(tv[k].feat);
      wait_result(tv[k].name, tv[k].cls, tv[k].dep, tv[k].err, tv[k].dep + 1, 1'b1);
    end

    cfg_write(0, mk(0, 0, 0, 0, 0, 0));
    send(NF'({$urandom, $urandom}));
    wait_result("self_loop", 0, 16, 1, 17, 1'b1);

    cfg_write(0, mk(0, 55, 0, 1, 1, 0));
    send('0);
    wait_result("bad_fidx", 0, 0, 1, 1, 1'b1);

    // Backpressure: result must hold while config writes and new vectors are refused
    program_test_tree();
    send(f18);
    wait_result("bp first", 1, 2, 0, 3, 1'b0);
    cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = pack(mk(1, 0, 0, 0, 0, 3));
    in_valid = 1'b1; i = f50;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp out_valid", 32'(out_valid), 32'(1));
      check("bp out_class", 32'(out_class), 32'(1));
      check("bp out_depth", 32'(out_depth), 32'(2));
      check("bp in_ready", 32'(in_ready), 32'(0));
      check("bp cfg_ready", 32'(cfg_ready), 32'(0));
    end
    cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp release out_valid", 32'(out_valid), 32'(0));
    check("bp release in_ready", 32'(in_ready), 32'(1));
    run_vec("bp after", '0);

    // Config write and vector offered together: write first, accept on the next cycle
    cfg_we = 1'b1; cfg_addr = 6'd1; cfg_wdata = pack(mk(1, 0, 0, 0, 0, 3));
    in_valid = 1'b1; i = f50;
    @(negedge clk);
    check("sim in_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1 cfg_we = 1'b0;
    m_tab[1] = mk(1, 0, 0, 0, 0, 3);
    @(negedge clk);
    check("sim in_ready next", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result("sim", 3, 1, 0, 2, 1'b1);

    for (int t = 0; t < 3; t++) begin
      for (int a = 0; a < 64; a++)
        cfg_write(a, mk(($urandom_range(0, 99) < 35) ? 1 : 0, $urandom_range(0, 55),
                        $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 63),
                        $urandom_range(0, 3)));
      for (int v = 0; v < 20; v++) run_vec("random", NF'({$urandom, $urandom}));
    end

    // Reset in the middle of a long walk discards the walk and the table
    cfg_write(0, mk(0, 0, 0, 0, 0, 0));
    send('0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'(0));
    check("midrst in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("midrst no result", 32'(seen), 32'(0));
    end
    send('0);
    wait_result("after_rst", 0, 0, 0, 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
